ofdm_channel_equalizer: RTL and testbench

//  Per-subcarrier channel equalizer for the OFDM receive chain, between FFT output and demapper.

---
 rtl/ofdm_eq_pkg.sv | 38 +++
 rtl/ofdm_eq_cmul.sv | 48 ++++
 rtl/ofdm_channel_equalizer.sv | 133 +++++++++++++
 tb/tb_ofdm_channel_equalizer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_eq_pkg.sv
// Shared types and the round/narrow helper for the OFDM channel equalizer.
// OFDM_EQ_SAT_EN selects saturating narrowing; otherwise results wrap.
package ofdm_eq_pkg;

  localparam int CPLX_IN_W  = 17;
  localparam int CPLX_OUT_W = 16;
  localparam int PROD_W     = 2 * CPLX_IN_W + 1;

  typedef enum logic [1:0] {IDLE, TRAIN, EQ} eq_state_t;

  typedef struct packed {
    logic signed [CPLX_IN_W-1:0] i;
    logic signed [CPLX_IN_W-1:0] q;
  } cplx_in_t;

  typedef struct packed {
    logic signed [CPLX_OUT_W-1:0] i;
    logic signed [CPLX_OUT_W-1:0] q;
  } cplx_out_t;

  localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'((2 ** (CPLX_OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN = -OUT_MAX - PROD_W'(1);

  // Round half up, arithmetic shift, then narrow to the output component width.
  function automatic logic signed [CPLX_OUT_W-1:0] round_narrow(
    input logic signed [PROD_W-1:0] p,
    input int                       shift
  );
    logic signed [PROD_W-1:0] r;
    r = (p + (PROD_W'(1) <<< (shift - 1))) >>> shift;
`ifdef OFDM_EQ_SAT_EN
    if (r > OUT_MAX)      r = OUT_MAX;
    else if (r < OUT_MIN) r = OUT_MIN;
`endif
    return CPLX_OUT_W'(r);
  endfunction

endpackage

// File: rtl/ofdm_eq_cmul.sv
// Two-stage pipelined Y * conj(H): registered partial products, then sum,
// round and narrow into the output register. Advances only when en is high.
module ofdm_eq_cmul
  import ofdm_eq_pkg::*;
#(
  parameter int SHIFT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [CPLX_IN_W-1:0]  yi,
  input  logic signed [CPLX_IN_W-1:0]  yq,
  input  logic signed [CPLX_IN_W-1:0]  hi,
  input  logic signed [CPLX_IN_W-1:0]  hq,
  output logic signed [CPLX_OUT_W-1:0] oi,
  output logic signed [CPLX_OUT_W-1:0] oq
);

  localparam int PW = 2 * CPLX_IN_W;

  logic signed [PW-1:0]     yihi_p2, yqhq_p2, yqhi_p2, yihq_p2;
  logic signed [PROD_W-1:0] pi_p2, pq_p2;

  // S2: four full-precision products
  always_ff @(posedge clk) begin
    if (en) begin
      yihi_p2 <= PW'(yi) * PW'(hi);
      yqhq_p2 <= PW'(yq) * PW'(hq);
      yqhi_p2 <= PW'(yq) * PW'(hi);
      yihq_p2 <= PW'(yi) * PW'(hq);
    end
  end

  assign pi_p2 = PROD_W'(yihi_p2) + PROD_W'(yqhq_p2);
  assign pq_p2 = PROD_W'(yqhi_p2) - PROD_W'(yihq_p2);

  // S3: sum, round, narrow into the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oi <= '0;
      oq <= '0;
    end else if (en) begin
      oi <= round_narrow(pi_p2, SHIFT);
      oq <= round_narrow(pq_p2, SHIFT);
    end
  end

endmodule

// File: rtl/ofdm_channel_equalizer.sv
// Per-subcarrier OFDM equalizer: learns H[k] from a (+1,0) training symbol, then
// emits Y[k]*conj(H[k]) scaled and narrowed. Narrowing mode set by OFDM_EQ_SAT_EN.
module ofdm_channel_equalizer
  import ofdm_eq_pkg::*;
#(
  parameter int IN_W  = CPLX_IN_W,
  parameter int OUT_W = CPLX_OUT_W,
  parameter int NSC   = 64,
  parameter int SHIFT = 16
) (
  input  logic                  clock_clk,
  input  logic                  reset_reset,
  input  logic [2*IN_W-1:0]     asi_in0_data,
  input  logic                  asi_in0_valid,
  input  logic                  asi_in0_startofpacket,
  output logic                  asi_in0_ready,
  output logic [2*OUT_W-1:0]    aso_out0_data,
  output logic                  aso_out0_valid,
  output logic                  aso_out0_startofpacket,
  output logic                  aso_out0_endofpacket,
  input  logic                  aso_out0_ready,
  output logic                  eq_trained
);

  localparam int AW = $clog2(NSC);

  eq_state_t      state, state_d;
  logic [AW-1:0]  sc_cnt, sc_cnt_d, k_cur;
  logic           trained_d, en, accept, emit, we;
  cplx_in_t       y_in, h_rd_p1;
  logic signed [IN_W-1:0]  yi_p1, yq_p1;
  logic           vld_p1, sop_p1, eop_p1, vld_p2, sop_p2, eop_p2;
  logic signed [OUT_W-1:0] oi, oq;
  logic [2*IN_W-1:0] h_ram [NSC];

  assign en            = !aso_out0_valid || aso_out0_ready;
  assign asi_in0_ready = en;
  assign accept        = asi_in0_valid && en;
  assign y_in          = asi_in0_data;

  always_comb begin
    state_d   = state;
    sc_cnt_d  = sc_cnt;
    trained_d = eq_trained;
    k_cur     = sc_cnt;
    emit      = 1'b0;
    we        = 1'b0;
    if (accept) begin
      if (asi_in0_startofpacket) begin
        k_cur     = '0;
        we        = 1'b1;
        state_d   = TRAIN;
        sc_cnt_d  = AW'(1);
        trained_d = 1'b0;
      end else begin
        case (state)
          TRAIN: begin
            we       = 1'b1;
            sc_cnt_d = sc_cnt + AW'(1);
            if (sc_cnt == AW'(NSC - 1)) begin
              state_d   = EQ;
              trained_d = 1'b1;
            end
          end
          EQ: begin
            emit     = 1'b1;
            sc_cnt_d = sc_cnt + AW'(1);
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state                  <= IDLE;
      sc_cnt                 <= '0;
      eq_trained             <= 1'b0;
      vld_p1                 <= 1'b0;
      sop_p1                 <= 1'b0;
      eop_p1                 <= 1'b0;
      vld_p2                 <= 1'b0;
      sop_p2                 <= 1'b0;
      eop_p2                 <= 1'b0;
      aso_out0_valid         <= 1'b0;
      aso_out0_startofpacket <= 1'b0;
      aso_out0_endofpacket   <= 1'b0;
    end else begin
      state      <= state_d;
      sc_cnt     <= sc_cnt_d;
      eq_trained <= trained_d;
      if (en) begin
        vld_p1                 <= emit;
        sop_p1                 <= emit && (k_cur == '0);
        eop_p1                 <= emit && (k_cur == AW'(NSC - 1));
        vld_p2                 <= vld_p1;
        sop_p2                 <= sop_p1;
        eop_p2                 <= eop_p1;
        aso_out0_valid         <= vld_p2;
        aso_out0_startofpacket <= sop_p2;
        aso_out0_endofpacket   <= eop_p2;
      end
    end
  end

  // S1: register Y and read H[k]; training writes never target a live EQ read
  always_ff @(posedge clock_clk) begin
    if (we) h_ram[k_cur] <= asi_in0_data;
    if (en) begin
      h_rd_p1 <= h_ram[k_cur];
      yi_p1   <= y_in.i;
      yq_p1   <= y_in.q;
    end
  end

  ofdm_eq_cmul #(
    .SHIFT (SHIFT)
  ) u_cmul (
    .clk (clock_clk),
    .rst (reset_reset),
    .en  (en),
    .yi  (yi_p1),
    .yq  (yq_p1),
    .hi  (h_rd_p1.i),
    .hq  (h_rd_p1.q),
    .oi  (oi),
    .oq  (oq)
  );

  assign aso_out0_data = {oi, oq};

endmodule

// File: tb/tb_ofdm_channel_equalizer.sv
// Directed self-checking bench for ofdm_channel_equalizer (64 SC, SHIFT 16).
module tb_ofdm_channel_equalizer;

  logic        clock_clk = 1'b0;
  logic        reset_reset;
  logic [33:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_startofpacket;
  logic        asi_in0_ready;
  logic [31:0] aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;
  logic        aso_out0_ready;
  logic        eq_trained;

  int checks = 0;
  int errors = 0;
  logic [33:0] out_q[$];
  bit bp_run = 1'b0;

  always #5 clock_clk = ~clock_clk;

  ofdm_channel_equalizer dut (
    .clock_clk              (clock_clk),
    .reset_reset            (reset_reset),
    .asi_in0_data           (asi_in0_data),
    .asi_in0_valid          (asi_in0_valid),
    .asi_in0_startofpacket  (asi_in0_startofpacket),
    .asi_in0_ready          (asi_in0_ready),
    .aso_out0_data          (aso_out0_data),
    .aso_out0_valid         (aso_out0_valid),
    .aso_out0_startofpacket (aso_out0_startofpacket),
    .aso_out0_endofpacket   (aso_out0_endofpacket),
    .aso_out0_ready         (aso_out0_ready),
    .eq_trained             (eq_trained)
  );

  always @(negedge clock_clk)
    if (!reset_reset && aso_out0_valid && aso_out0_ready)
      out_q.push_back({aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data});

  // Entered and left at 1 time unit after a rising edge.
  task automatic send(input int i, input int q, input logic sop);
    logic acc;
    int n;
    asi_in0_data = {17'(i), 17'(q)};
    asi_in0_valid = 1'b1;
    asi_in0_startofpacket = sop;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clock_clk);
      acc = asi_in0_ready;
      @(posedge clock_clk);
      #1;
      n++;
    end
    asi_in0_valid = 1'b0;
    asi_in0_startofpacket = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles, required accept", n);
    end
  endtask

  task automatic send_sym(input int i, input int q, input logic with_sop);
    for (int k = 0; k < 64; k++) send(i, q, with_sop && (k == 0));
  endtask

  task automatic wait_out(input int n, input string name);
    int c = 0;
    while (out_q.size() < n && c < 3000) begin
      @(posedge clock_clk);
      #1;
      c++;
    end
    repeat (5) begin
      @(posedge clock_clk);
      #1;
    end
    checks++;
    if (out_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    asi_in0_data = '0;
    asi_in0_valid = 1'b0;
    asi_in0_startofpacket = 1'b0;
    aso_out0_ready = 1'b1;
    repeat (3) @(posedge clock_clk);
    #1;
    checks++;
    if (aso_out0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", aso_out0_valid); end
    checks++;
    if ({aso_out0_startofpacket, aso_out0_endofpacket} !== 2'b00) begin
      errors++; $display("FAIL reset_sop_eop: got %b%b required 00", aso_out0_startofpacket, aso_out0_endofpacket);
    end
    checks++;
    if (aso_out0_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", aso_out0_data); end
    checks++;
    if (eq_trained !== 1'b0) begin errors++; $display("FAIL reset_trained: got %b required 0", eq_trained); end
    checks++;
    if (asi_in0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", asi_in0_ready); end
    reset_reset = 1'b0;
    @(posedge clock_clk);
    #1;
  endtask

  task automatic test_drop_before_sop();
    for (int k = 0; k < 5; k++) send(1000, 0, 1'b0);
    wait_out(0, "drop_pre_sop");
    checks++;
    if (eq_trained !== 1'b0) begin errors++; $display("FAIL drop_trained: got %b required 0", eq_trained); end
  endtask

  task automatic test_basic();
    logic [33:0] e, x;
    for (int k = 0; k < 63; k++) send(16384, 0, k == 0);
    checks++;
    if (eq_trained !== 1'b0) begin errors++; $display("FAIL basic_trained_63: got %b required 0", eq_trained); end
    send(16384, 0, 1'b0);
    checks++;
    if (eq_trained !== 1'b1) begin errors++; $display("FAIL basic_trained_64: got %b required 1", eq_trained); end
    wait_out(0, "basic_train_silent");
    send_sym(1000, -2000, 1'b0);
    wait_out(64, "basic");
    for (int k = 0; k < 64; k++) begin
      e = {k == 0, k == 63, 16'(250), 16'(-500)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL basic k=%0d: got %h required %h", k, x, e); end
    end
    // half-LSB ties: +0.5 -> 1, -1.5 -> -1
    send_sym(2, -6, 1'b0);
    wait_out(64, "round");
    for (int k = 0; k < 64; k++) begin
      e = {k == 0, k == 63, 16'(1), 16'(-1)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL round k=%0d: got %h required %h", k, x, e); end
    end
  endtask

  task automatic test_conj();
    logic [33:0] e, x;
    send_sym(0, 16384, 1'b1);
    checks++;
    if (eq_trained !== 1'b1) begin errors++; $display("FAIL conj_trained: got %b required 1", eq_trained); end
    send_sym(1000, 0, 1'b0);
    wait_out(64, "conj");
    for (int k = 0; k < 64; k++) begin
      e = {k == 0, k == 63, 16'(0), 16'(-250)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL conj k=%0d: got %h required %h", k, x, e); end
    end
  endtask

  task automatic test_narrow();
    logic [33:0] e, x;
    int ei;
`ifdef OFDM_EQ_SAT_EN
    ei = 32767;
`else
    ei = -2;
`endif
    send_sym(65535, 0, 1'b1);
    send_sym(65535, 0, 1'b0);
    wait_out(64, "narrow");
    for (int k = 0; k < 64; k++) begin
      e = {k == 0, k == 63, 16'(ei), 16'(0)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL narrow k=%0d: got %h required %h", k, x, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] e, x;
    int n;
    send_sym(16384, 0, 1'b1);
    bp_run = 1'b1;
    fork
      begin
        while (bp_run) begin
          @(posedge clock_clk);
          #1;
          aso_out0_ready = ($urandom_range(0, 1) == 1);
        end
        aso_out0_ready = 1'b1;
      end
    join_none
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 64; k++) begin
        n = s * 64 + k;
        send(4 * n, -8 * n, 1'b0);
      end
    wait_out(256, "backpressure");
    bp_run = 1'b0;
    repeat (3) @(posedge clock_clk);
    #1;
    for (int m = 0; m < 256; m++) begin
      e = {(m % 64) == 0, (m % 64) == 63, 16'(m), 16'(-2 * m)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL backpressure n=%0d: got %h required %h", m, x, e); end
    end
  endtask

  task automatic test_mid_sop();
    logic [33:0] e, x;
    for (int k = 0; k < 20; k++) send(400, 0, 1'b0);
    wait_out(20, "mid_pre");
    for (int k = 0; k < 20; k++) begin
      e = {k == 0, 1'b0, 16'(100), 16'(0)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL mid_pre k=%0d: got %h required %h", k, x, e); end
    end
    send(0, 16384, 1'b1);
    checks++;
    if (eq_trained !== 1'b0) begin errors++; $display("FAIL mid_untrained: got %b required 0", eq_trained); end
    for (int k = 1; k < 64; k++) send(0, 16384, 1'b0);
    wait_out(0, "mid_train_silent");
    checks++;
    if (eq_trained !== 1'b1) begin errors++; $display("FAIL mid_retrained: got %b required 1", eq_trained); end
    send_sym(1000, 0, 1'b0);
    wait_out(64, "mid_post");
    for (int k = 0; k < 64; k++) begin
      e = {k == 0, k == 63, 16'(0), 16'(-250)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL mid_post k=%0d: got %h required %h", k, x, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] e, x;
    for (int k = 0; k < 3; k++) send(1000, 0, 1'b0);
    reset_reset = 1'b1;
    #1;
    checks++;
    if (aso_out0_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b required 0", aso_out0_valid); end
    checks++;
    if (eq_trained !== 1'b0) begin errors++; $display("FAIL rstmid_trained: got %b required 0", eq_trained); end
    @(posedge clock_clk);
    #1;
    reset_reset = 1'b0;
    out_q.delete();
    for (int k = 0; k < 10; k++) send(1000, 0, 1'b0);
    wait_out(0, "rstmid_idle");
    send_sym(16384, 0, 1'b1);
    send_sym(1000, -2000, 1'b0);
    wait_out(64, "rstmid_resume");
    for (int k = 0; k < 64; k++) begin
      e = {k == 0, k == 63, 16'(250), 16'(-500)};
      x = out_q.pop_front();
      checks++;
      if (x !== e) begin errors++; $display("FAIL rstmid_resume k=%0d: got %h required %h", k, x, e); end
    end
  endtask

  initial begin
    test_reset();
    test_drop_before_sop();
    test_basic();
    test_conj();
    test_narrow();
    test_backpressure();
    test_mid_sop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
